// File: rtl/pipe_idex_hazard.sv
// rtl/pipe_idex_hazard.sv - ID/EX pipeline register with load-use hazard detection and flush
//
// Purpose:
//   Holds the decoded ID-stage state for the EX stage. It detects a load in EX
//   whose destination is read by the instruction in ID. On that hazard it
//   freezes PC and IF/ID for one cycle and loads a bubble into ID/EX. A
//   branch/jump flush also loads a bubble and takes priority over a hazard.
//   StallCnt counts the hazard bubbles and saturates at all-ones.
//
// Ports:
//   clk, reset                        clock (rising edge), async active-low reset
//   IFIDRs, IFIDRt, ID_UsesRt         source fields of the instruction in ID
//   ID_Rd, ID_RegWr, ID_MemRd,
//   ID_MemWr, ID_ALUOp                decoded control of the instruction in ID
//   ID_BusA, ID_BusB, ID_Imm          operand data of the instruction in ID
//   ID_Flush                          squash the instruction in ID
//   IDEXRs .. IDEXImm                 registered ID/EX state, feeds EX and forwarding
//   PCWr, IFIDWr                      PC and IF/ID write enables (low only while stalling)
//   StallCnt                          saturating count of load-use bubbles

module pipe_idex_hazard #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         IFIDRs,
  input  logic [4:0]         IFIDRt,
  input  logic               ID_UsesRt,
  input  logic [4:0]         ID_Rd,
  input  logic               ID_RegWr,
  input  logic               ID_MemRd,
  input  logic               ID_MemWr,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  input  logic [DATA_W-1:0]  ID_BusA,
  input  logic [DATA_W-1:0]  ID_BusB,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic               ID_Flush,
  output logic [4:0]         IDEXRs,
  output logic [4:0]         IDEXRt,
  output logic [4:0]         IDEXRd,
  output logic               IDEXRegWr,
  output logic               IDEXMemRd,
  output logic               IDEXMemWr,
  output logic [ALUOP_W-1:0] IDEXALUOp,
  output logic [DATA_W-1:0]  IDEXBusA,
  output logic [DATA_W-1:0]  IDEXBusB,
  output logic [DATA_W-1:0]  IDEXImm,
  output logic               PCWr,
  output logic               IFIDWr,
  output logic [CNT_W-1:0]   StallCnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic rd_nonzero;
  logic rs_match;
  logic rt_match;
  logic haz;
  logic stall;
  logic bubble;
  logic cnt_full;

  // The hazard depends only on the registered EX state and the ID source
  // fields. It never depends on ID data, so there is no combinational
  // ID-data-to-IDEX path. A destination of $0 can never create a dependency.
  assign rd_nonzero = |IDEXRd;
  assign rs_match   = (IDEXRd == IFIDRs);
  assign rt_match   = ID_UsesRt & (IDEXRd == IFIDRt);
  assign haz        = IDEXMemRd & rd_nonzero & (rs_match | rt_match);

  // A flush throws away the instruction in ID, so there is nothing left to
  // stall for. The flush wins and the hazard is not counted.
  assign stall  = haz & ~ID_Flush;
  assign bubble = haz | ID_Flush;

  // While reset is low the registers are already cleared, which removes the
  // hazard. The explicit reset term also makes the enables return to 1 the
  // instant reset asserts, independent of register clear timing.
  assign PCWr   = ~stall | ~reset;
  assign IFIDWr = ~stall | ~reset;

  assign cnt_full = &StallCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IDEXRs    <= '0;
      IDEXRt    <= '0;
      IDEXRd    <= '0;
      IDEXRegWr <= 1'b0;
      IDEXMemRd <= 1'b0;
      IDEXMemWr <= 1'b0;
      IDEXALUOp <= '0;
      IDEXBusA  <= '0;
      IDEXBusB  <= '0;
      IDEXImm   <= '0;
    end else if (bubble) begin
      // An all-zero bubble has RegWr=0 and Rd=0, so forwarding ignores it.
      // Its MemRd=0 clears the hazard on the next cycle.
      IDEXRs    <= '0;
      IDEXRt    <= '0;
      IDEXRd    <= '0;
      IDEXRegWr <= 1'b0;
      IDEXMemRd <= 1'b0;
      IDEXMemWr <= 1'b0;
      IDEXALUOp <= '0;
      IDEXBusA  <= '0;
      IDEXBusB  <= '0;
      IDEXImm   <= '0;
    end else begin
      IDEXRs    <= IFIDRs;
      IDEXRt    <= IFIDRt;
      IDEXRd    <= ID_Rd;
      IDEXRegWr <= ID_RegWr;
      IDEXMemRd <= ID_MemRd;
      IDEXMemWr <= ID_MemWr;
      IDEXALUOp <= ID_ALUOp;
      IDEXBusA  <= ID_BusA;
      IDEXBusB  <= ID_BusB;
      IDEXImm   <= ID_Imm;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCnt <= '0;
    end else if (stall && !cnt_full) begin
      StallCnt <= StallCnt + CNT_ONE;
    end
  end

endmodule
